// File: rtl/traffic_pkg.sv
// Shared types for the UK-sequence traffic light controller: phase enum and lamp decode.
package traffic_pkg;

    typedef enum logic [2:0] {
        RED,
        RED_AMBER,
        GREEN,
        AMBER,
        WALK
    } light_state_t;

    typedef struct packed {
        logic red;
        logic amber;
        logic green;
        logic walk;
    } lamps_t;

    function automatic lamps_t lamp_decode(light_state_t s);
        lamps_t l;
        l = '{red: 1'b0, amber: 1'b0, green: 1'b0, walk: 1'b0};
        case (s)
            RED:       l.red = 1'b1;
            RED_AMBER: begin l.red = 1'b1; l.amber = 1'b1; end
            GREEN:     l.green = 1'b1;
            AMBER:     l.amber = 1'b1;
            WALK:      begin l.red = 1'b1; l.walk = 1'b1; end
            // Unused encodings show red so a corrupted state fails safe.
            default:   l.red = 1'b1;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_if.sv
// Lamp/enable/pedestrian bundle between the controller (slave) and whatever drives it (master).
interface traffic_if;
    logic en;
    logic ped_req;
    logic red;
    logic amber;
    logic green;
    logic walk;
    logic ped_ack;

    modport master (
        output en, ped_req,
        input  red, amber, green, walk, ped_ack
    );

    modport slave (
        input  en, ped_req,
        output red, amber, green, walk, ped_ack
    );
endinterface

// File: rtl/traffic_phase_timer.sv
// Phase down-counter: reloads on load, otherwise counts down to 0 and holds there.
module phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RST_VAL;
        end else if (en) begin
            if (load)
                count <= load_val;
            else if (count != '0)
                count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/traffic_ctrl.sv
// UK-sequence traffic light controller with parametrised phase durations.
// Optional pedestrian WALK phase is built only when TRAFFIC_PED_EN is defined.
module traffic_ctrl
    import traffic_pkg::*;
#(
    parameter int CNT_W            = 8,
    parameter int RED_CYCLES       = 8,
    parameter int RED_AMBER_CYCLES = 2,
    parameter int GREEN_CYCLES     = 8,
    parameter int AMBER_CYCLES     = 3,
    parameter int WALK_CYCLES      = 6
) (
    input logic      clk,
    input logic      rst_n,
    traffic_if.slave bus
);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam longint MAX_DUR = 64'd1 << CNT_W;

    if (RED_CYCLES < 1 || RED_CYCLES > MAX_DUR) begin : g_bad_red
        $error("traffic_ctrl: RED_CYCLES out of range 1..2^CNT_W");
    end
    if (RED_AMBER_CYCLES < 1 || RED_AMBER_CYCLES > MAX_DUR) begin : g_bad_red_amber
        $error("traffic_ctrl: RED_AMBER_CYCLES out of range 1..2^CNT_W");
    end
    if (GREEN_CYCLES < 1 || GREEN_CYCLES > MAX_DUR) begin : g_bad_green
        $error("traffic_ctrl: GREEN_CYCLES out of range 1..2^CNT_W");
    end
    if (AMBER_CYCLES < 1 || AMBER_CYCLES > MAX_DUR) begin : g_bad_amber
        $error("traffic_ctrl: AMBER_CYCLES out of range 1..2^CNT_W");
    end
`ifdef TRAFFIC_PED_EN
    if (WALK_CYCLES < 1 || WALK_CYCLES > MAX_DUR) begin : g_bad_walk
        $error("traffic_ctrl: WALK_CYCLES out of range 1..2^CNT_W");
    end
`endif

    function automatic cnt_t load_value(light_state_t s);
        case (s)
            RED:       return cnt_t'(RED_CYCLES - 1);
            RED_AMBER: return cnt_t'(RED_AMBER_CYCLES - 1);
            GREEN:     return cnt_t'(GREEN_CYCLES - 1);
            AMBER:     return cnt_t'(AMBER_CYCLES - 1);
            WALK:      return cnt_t'(WALK_CYCLES - 1);
            default:   return cnt_t'(RED_CYCLES - 1);
        endcase
    endfunction

    light_state_t state, state_next;
    lamps_t       lamps;
    logic         timer_done;
    logic         advance;
    cnt_t         load_val;
    logic         ped_pending;

    assign advance  = bus.en && timer_done;
    assign load_val = load_value(state_next);

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (cnt_t'(RED_CYCLES - 1))
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (bus.en),
        .load     (advance),
        .load_val (load_val),
        .done     (timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RED;
        else if (advance)
            state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            RED:       state_next = RED_AMBER;
            RED_AMBER: state_next = GREEN;
            GREEN:     state_next = AMBER;
            AMBER:     state_next = ped_pending ? WALK : RED;
            WALK:      state_next = RED;
            default:   state_next = RED;
        endcase
    end

    always_comb begin
        lamps = lamp_decode(state);
`ifdef TRAFFIC_PED_EN
`else
        lamps.walk = 1'b0;
`endif
    end

    assign bus.red   = lamps.red;
    assign bus.amber = lamps.amber;
    assign bus.green = lamps.green;
    assign bus.walk  = lamps.walk;

`ifdef TRAFFIC_PED_EN
    light_state_t state_after;
    logic         ped_accept;
    logic         ped_ack_q;

    // A request is dropped while in WALK or on the edge that enters WALK.
    assign state_after = advance ? state_next : state;
    assign ped_accept  = bus.ped_req && !ped_pending &&
                         (state != WALK) && (state_after != WALK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pending <= 1'b0;
            ped_ack_q   <= 1'b0;
        end else begin
            ped_ack_q <= ped_accept;
            if (advance && state_next == WALK)
                ped_pending <= 1'b0;
            else if (ped_accept)
                ped_pending <= 1'b1;
        end
    end

    assign bus.ped_ack = ped_ack_q;
`else
    logic unused_ped_req;

    assign ped_pending    = 1'b0;
    assign unused_ped_req = bus.ped_req;
    assign bus.ped_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_ctrl.sv
// Bench for traffic_ctrl: default-timing and all-ones instances against a phase/elapsed model.
module tb_traffic_ctrl;

`ifdef TRAFFIC_PED_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    traffic_if bus_a ();
    traffic_if bus_b ();

    traffic_ctrl u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    traffic_ctrl #(
        .CNT_W            (1),
        .RED_CYCLES       (1),
        .RED_AMBER_CYCLES (1),
        .GREEN_CYCLES     (1),
        .AMBER_CYCLES     (1),
        .WALK_CYCLES      (1)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: phase index (0 red, 1 red+amber, 2 green, 3 amber, 4 walk) plus enabled cycles spent in it.
    int dur [2][5] = '{'{8, 2, 8, 3, 6}, '{1, 1, 1, 1, 1}};
    int phase   [2];
    int elapsed [2];
    bit pend    [2];
    bit ack     [2];

    function automatic logic [3:0] lamp_pat(input int p);
        case (p)
            0:       return 4'b1000;
            1:       return 4'b1100;
            2:       return 4'b0010;
            3:       return 4'b0100;
            4:       return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            phase[k]   = 0;
            elapsed[k] = 0;
            pend[k]    = 1'b0;
            ack[k]     = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input logic en, input logic req);
        int nxt;
        bit adv;
        bit accept;
        adv = en && (elapsed[k] + 1 == dur[k][phase[k]]);
        nxt = phase[k];
        if (adv) begin
            if (phase[k] == 3)      nxt = (PED && pend[k]) ? 4 : 0;
            else if (phase[k] == 4) nxt = 0;
            else                    nxt = phase[k] + 1;
        end
        accept = PED && req && !pend[k] && phase[k] != 4 && nxt != 4;
        if (adv && nxt == 4) pend[k] = 1'b0;
        else if (accept)     pend[k] = 1'b1;
        ack[k] = accept;
        if (en) begin
            if (adv) begin
                phase[k]   = nxt;
                elapsed[k] = 0;
            end else begin
                elapsed[k]++;
            end
        end
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(0, bus_a.en, bus_a.ped_req);
            model_step(1, bus_b.en, bus_b.ped_req);
        end
    end

    function automatic logic [3:0] la();
        return {bus_a.red, bus_a.amber, bus_a.green, bus_a.walk};
    endfunction

    function automatic logic [3:0] lb();
        return {bus_b.red, bus_b.amber, bus_b.green, bus_b.walk};
    endfunction

    always @(negedge clk) begin
        check("a_lamps", la(), lamp_pat(phase[0]));
        check("a_ack", bus_a.ped_ack, ack[0]);
        check("b_lamps", lb(), lamp_pat(phase[1]));
        check("b_ack", bus_b.ped_ack, ack[1]);
    end

    // Default-timing expectation for an unpaused, request-free run, t cycles after reset release.
    function automatic logic [3:0] exp_default(input int t);
        int m;
        m = t % 21;
        if (m < 8)       return 4'b1000;
        else if (m < 10) return 4'b1100;
        else if (m < 18) return 4'b0010;
        else             return 4'b0100;
    endfunction

    task automatic wait_a(input logic [3:0] pat, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            #1;
            hit = (la() == pat);
        end
        check(name, hit, 1'b1);
    endtask

    task automatic pulse_req_a();
        bus_a.ped_req = 1'b1;
        @(negedge clk);
        #1;
        bus_a.ped_req = 1'b0;
    endtask

    int green_cnt;
    int walk_cnt;
    int ack_cnt;

    initial begin
        bus_a.en = 1'b0; bus_a.ped_req = 1'b0;
        bus_b.en = 1'b0; bus_b.ped_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_a_lamps", la(), 4'b1000);
        check("rst_a_ack", bus_a.ped_ack, 1'b0);
        check("rst_b_lamps", lb(), 4'b1000);

        @(negedge clk);
        rst_n = 1'b1;
        bus_a.en = 1'b1;
        bus_b.en = 1'b1;
        #1;
        for (int t = 0; t < 63; t++) begin
            if (t > 0) begin
                @(negedge clk);
                #1;
            end
            check("seq_a", la(), exp_default(t));
            check("seq_b", lb(), lamp_pat(t % 4));
        end

        // Pause mid-green for 5 cycles.
        wait_a(4'b0010, "wait_green_pause");
        green_cnt = 1;
        repeat (2) begin
            @(negedge clk);
            #1;
            if (bus_a.green) green_cnt++;
        end
        bus_a.en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            check("pause_stable", la(), 4'b0010);
            if (bus_a.green) green_cnt++;
        end
        bus_a.en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (!bus_a.green) break;
            green_cnt++;
        end
        check("green_wall_cycles", green_cnt, 13);

`ifdef TRAFFIC_PED_EN
        // Single-cycle request during green.
        wait_a(4'b0010, "wait_green_ped");
        pulse_req_a();
        ack_cnt = 0;
        walk_cnt = 0;
        for (int i = 0; i < 45; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            ack_cnt += int'(bus_a.ped_ack);
            if (bus_a.walk) begin
                walk_cnt++;
                check("walk_with_red", la(), 4'b1001);
            end
        end
        check("ped_ack_count", ack_cnt, 1);
        check("walk_cycles_one_round", walk_cnt, 6);

        // Request held high through WALK.
        wait_a(4'b0010, "wait_green_held");
        pulse_req_a();
        wait_a(4'b1001, "wait_walk_held");
        bus_a.ped_req = 1'b1;
        ack_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            ack_cnt += int'(bus_a.ped_ack);
            if (!bus_a.walk) break;
        end
        check("no_ack_in_walk", ack_cnt, 0);
        @(negedge clk);
        #1;
        check("ack_after_walk", bus_a.ped_ack, 1'b1);
        bus_a.ped_req = 1'b0;
        walk_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            if (bus_a.walk) walk_cnt++;
        end
        check("held_req_served", walk_cnt, 6);

        wait_a(4'b0010, "wait_green_rst");
        pulse_req_a();
`endif

        // Asynchronous reset in the middle of amber.
        wait_a(4'b0100, "wait_amber_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_lamps", la(), 4'b1000);
        check("async_rst_ack", bus_a.ped_ack, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        walk_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (bus_a.walk) walk_cnt++;
        end
        check("no_walk_after_rst", walk_cnt, 0);

        // Random enable and request traffic on both instances.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            #1;
            bus_a.en      = ($urandom % 8) != 0;
            bus_a.ped_req = ($urandom % 12) == 0;
            bus_b.en      = ($urandom % 6) != 0;
            bus_b.ped_req = ($urandom % 5) == 0;
        end
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl.md
# traffic_ctrl

Parametrised UK-sequence traffic light controller: red → red+amber → green → amber → red. Phase durations are set by parameters, and an `en` input can pause the sequence. An optional pedestrian phase is entered on a latched request. It replaces the fixed-timing `traffic` block and drives the lamp outputs directly from a single clock domain.

## Interface
- `CNT_W`, 8: phase timer width in bits.
- `RED_CYCLES`, 8: clock cycles spent in RED.
- `RED_AMBER_CYCLES`, 2: cycles spent in RED_AMBER.
- `GREEN_CYCLES`, 8: cycles spent in GREEN.
- `AMBER_CYCLES`, 3: cycles spent in AMBER.
- `WALK_CYCLES`, 6: cycles spent in WALK (pedestrian build only).
- Every duration is in the range 1..2^CNT_W. An out-of-range value is a `$error` at elaboration.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  advance enable; low freezes the timer and the state.
- `ped_req`  in  1  pedestrian request, level-sampled each edge.
- `red`  out  1  red lamp.
- `amber`  out  1  amber lamp.
- `green`  out  1  green lamp.
- `walk`  out  1  pedestrian walk lamp.
- `ped_ack`  out  1  one-cycle pulse; the request has been accepted.

## Operation
- States: RED, RED_AMBER, GREEN, AMBER, WALK.
- Lamp decode:
  - RED: red.
  - RED_AMBER: red and amber.
  - GREEN: green.
  - AMBER: amber.
  - WALK: red and walk.
- Lamps are a combinational decode of the registered state.
- Each state has a down-counter timer, loaded with duration−1 on entry.
- At each edge with `en`=1:
  - Timer ≠ 0: decrement.
  - Timer = 0: transition to the next state and load that state's timer.
- Each state therefore lasts exactly N enabled cycles.
- Transitions: RED→RED_AMBER→GREEN→AMBER; AMBER→WALK if `ped_pending`=1, otherwise AMBER→RED; WALK→RED.
- `ped_pending` register (sticky):
  - Set at an edge where `ped_req`=1, `ped_pending`=0, current state ≠ WALK, and next state ≠ WALK.
  - Requests not meeting these conditions are dropped and get no ack.
  - Cleared on the edge entering WALK.
- `ped_ack` is registered. It is high for the single cycle after each edge that sets `ped_pending`.
- The AMBER→WALK decision uses the registered `ped_pending`. A request accepted on the AMBER-expiry edge is served in the next round.
- With `en`=0:
  - State and timer hold; lamps are unchanged.
  - `ped_req` is still accepted, and `ped_ack` still pulses.
- Duration 1 means the state lasts one enabled cycle; the timer is loaded with 0.

## Timing
- Reset (async assert, no clock needed):
  - State RED, timer = RED_CYCLES−1, `ped_pending`=0.
  - Outputs: `red`=1, `amber`=0, `green`=0, `walk`=0, `ped_ack`=0.
- Reset mid-operation forces these values immediately. Deassertion is synchronised externally; the first enabled edge after release counts as RED cycle 1.
- Lamp outputs change in the same cycle as the state register; there is no added latency.
- Full cycle without a pedestrian request: RED+RED_AMBER+GREEN+AMBER enabled cycles (21 with defaults).
- With WALK: that sum + WALK_CYCLES (27 with defaults).
- The timer never wraps: it is reloaded at 0 and never decremented below 0.

## Configuration
- Macro: `TRAFFIC_PED_EN`.
- Defined:
  - WALK state, `ped_pending` and `ped_ack` logic are present, as described above.
- Undefined:
  - WALK state is absent; AMBER→RED always.
  - `ped_req` is ignored.
  - `walk` and `ped_ack` are tied to 0.
  - `WALK_CYCLES` is unused, with no range check.
- The port list is identical in both builds.

## Structure
- Shared package `traffic_pkg`:
  - `light_state_t` enum (RED, RED_AMBER, GREEN, AMBER, WALK).
  - Lamp-decode constant/function.
- Sub-module `phase_timer`:
  - Parametrised by `CNT_W`.
  - Inputs: `clk`, `rst_n`, `en`, `load`, `load_val`.
  - Output: `done` (count = 0).
  - Its reset value is supplied by the parent.
- Top level holds the state register, next-state logic and pedestrian logic.

## Test plan
- Defaults, `en`=1, no requests, from reset release:
  - Expected sequence: red for 8 cycles, red+amber 2, green 8, amber 3.
  - Red returns on cycle 22.
  - Check over 3 full periods.
- `TRAFFIC_PED_EN` defined, `ped_req` pulsed for 1 cycle during GREEN:
  - `ped_ack` high for exactly 1 cycle.
  - After amber: red+walk for 6 cycles, then red.
  - The next round has no WALK.
- `ped_req` held high throughout WALK:
  - No ack during WALK.
  - Accepted on the first edge after WALK exit; served in the following round.
- `en` dropped for 5 cycles mid-GREEN:
  - Green phase totals 13 wall-clock cycles.
  - Lamps stable while paused.
- `rst_n` asserted asynchronously mid-AMBER with a pending request:
  - Immediately `red`=1, `amber`=0.
  - Pending cleared; the next round has no WALK.
- All durations = 1, `CNT_W`=1:
  - The state advances every enabled cycle: 4-cycle period (5 with a request).
